// File: rtl/gpio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_irq
//  Brief    : Memory-bus GPIO with per-pin direction, input synchroniser,
//             programmable debounce filter, rise/fall edge detection,
//             sticky W1C pending bits and one level interrupt line.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_irq #(
    parameter  int GPIO_NUM    = 16,
    parameter  int SYNC_STAGES = 2,   // must be >= 2
    parameter  int DEBOUNCE_W  = 8,   // must be <= MEM_BUS_W
    parameter  int MEM_BUS_W   = 32,
    parameter  int INST_BUS_W  = 32,
    localparam int c_NPIN      = (GPIO_NUM > MEM_BUS_W) ? MEM_BUS_W : GPIO_NUM
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [INST_BUS_W-1:0] addr_i,
    input  logic [MEM_BUS_W-1:0]  data_i,
    output logic [MEM_BUS_W-1:0]  data_o,
    input  logic [c_NPIN-1:0]     io_pin_i,
    output logic [c_NPIN-1:0]     io_pin_o,
    output logic [c_NPIN-1:0]     io_oe_o,
    output logic                  irq_o
);

    localparam logic [4:0] c_OFF_DIR   = 5'h00;
    localparam logic [4:0] c_OFF_OUT   = 5'h04;
    localparam logic [4:0] c_OFF_IN    = 5'h08;
    localparam logic [4:0] c_OFF_RISE  = 5'h0C;
    localparam logic [4:0] c_OFF_FALL  = 5'h10;
    localparam logic [4:0] c_OFF_PEND  = 5'h14;
    localparam logic [4:0] c_OFF_DEBNC = 5'h18;

    logic [c_NPIN-1:0]     r_dir;
    logic [c_NPIN-1:0]     r_out;
    logic [c_NPIN-1:0]     r_rise;
    logic [c_NPIN-1:0]     r_fall;
    logic [c_NPIN-1:0]     r_pend;
    logic [DEBOUNCE_W-1:0] r_debnc;
    logic [c_NPIN-1:0]     r_sync [SYNC_STAGES];

    logic [4:0]            w_sel;
    logic                  w_wr_dir;
    logic                  w_wr_out;
    logic                  w_wr_rise;
    logic                  w_wr_fall;
    logic                  w_wr_pend;
    logic                  w_wr_debnc;
    logic [c_NPIN-1:0]     w_sync;
    logic [c_NPIN-1:0]     w_filt;
    logic [c_NPIN-1:0]     w_upd;
    logic [c_NPIN-1:0]     w_set;
    logic [c_NPIN-1:0]     w_clr;
    logic [MEM_BUS_W-1:0]  w_rdata;
    logic                  w_unused_bits;

    // Only the low five address bits select a register; the rest are ignored.
    assign w_sel         = addr_i[4:0];
    assign w_unused_bits = ^{addr_i, data_i};

    assign w_wr_dir   = we_i && (w_sel == c_OFF_DIR);
    assign w_wr_out   = we_i && (w_sel == c_OFF_OUT);
    assign w_wr_rise  = we_i && (w_sel == c_OFF_RISE);
    assign w_wr_fall  = we_i && (w_sel == c_OFF_FALL);
    assign w_wr_pend  = we_i && (w_sel == c_OFF_PEND);
    assign w_wr_debnc = we_i && (w_sel == c_OFF_DEBNC);

    assign w_clr = w_wr_pend ? data_i[c_NPIN-1:0] : '0;

    // An accepted filter transition raises pending when its direction is enabled.
    assign w_set = w_upd & ((w_sync & r_rise) | (~w_sync & r_fall));

    // Control registers and sticky pending bits; a new event beats a same-cycle W1C.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_dir   <= '0;
            r_out   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_pend  <= '0;
            r_debnc <= '0;
        end else begin
            if (w_wr_dir)   r_dir   <= data_i[c_NPIN-1:0];
            if (w_wr_out)   r_out   <= data_i[c_NPIN-1:0];
            if (w_wr_rise)  r_rise  <= data_i[c_NPIN-1:0];
            if (w_wr_fall)  r_fall  <= data_i[c_NPIN-1:0];
            if (w_wr_debnc) r_debnc <= data_i[DEBOUNCE_W-1:0];
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Multi-flop synchroniser bringing the asynchronous pads into clk_i.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= io_pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    for (genvar gi = 0; gi < c_NPIN; gi++) begin : g_pin
        logic                  r_filt;
        logic [DEBOUNCE_W-1:0] r_cnt;
        logic                  w_diff;
        logic                  w_ripe;

        // Using >= lets a threshold lowered mid-count still complete the transition.
        assign w_diff = w_sync[gi] ^ r_filt;
        assign w_ripe = (r_cnt >= r_debnc);

        // Debounce: the filtered value follows only after T+1 consecutive differing samples.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_filt <= 1'b0;
                r_cnt  <= '0;
            end else if (!w_diff) begin
                r_cnt  <= '0;
            end else if (w_ripe) begin
                r_filt <= w_sync[gi];
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        assign w_filt[gi] = r_filt;
        assign w_upd[gi]  = w_diff & w_ripe;
    end

    // Combinational read mux, forced to zero while reset is held.
    always_comb begin
        w_rdata = '0;
        if (rst_ni) begin
            case (w_sel)
                c_OFF_DIR:   w_rdata[c_NPIN-1:0]     = r_dir;
                c_OFF_OUT:   w_rdata[c_NPIN-1:0]     = r_out;
                c_OFF_IN:    w_rdata[c_NPIN-1:0]     = w_filt;
                c_OFF_RISE:  w_rdata[c_NPIN-1:0]     = r_rise;
                c_OFF_FALL:  w_rdata[c_NPIN-1:0]     = r_fall;
                c_OFF_PEND:  w_rdata[c_NPIN-1:0]     = r_pend;
                c_OFF_DEBNC: w_rdata[DEBOUNCE_W-1:0] = r_debnc;
                default:     w_rdata                 = '0;
            endcase
        end
    end

    assign data_o   = w_rdata;
    assign io_pin_o = r_out;
    assign io_oe_o  = r_dir;
    assign irq_o    = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_irq
//  Brief    : Self-checking bench for gpio_irq: directed scenarios followed by
//             randomized pin/bus traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_irq;

    localparam int c_N    = 16;
    localparam int c_SYNC = 2;
    localparam int c_DW   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [c_N-1:0]  pin;
    logic [c_N-1:0]  pin_o;
    logic [c_N-1:0]  oe;
    logic            irq;

    logic [31:0]     rdata2;
    logic [31:0]     pin2;
    logic [31:0]     pin_o2;
    logic [31:0]     oe2;
    logic            irq2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [c_N-1:0]  m_dir, m_out, m_rise, m_fall, m_pend, m_filt, m_last;
    logic [c_DW-1:0] m_t;
    logic [c_N-1:0]  m_sync_q [$];
    int              m_run [c_N];

    always #5 clk = ~clk;

    assign pin2 = '0;

    gpio_irq #(.GPIO_NUM(c_N), .SYNC_STAGES(c_SYNC), .DEBOUNCE_W(c_DW)) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .we_i     (we),
        .addr_i   (addr),
        .data_i   (wdata),
        .data_o   (rdata),
        .io_pin_i (pin),
        .io_pin_o (pin_o),
        .io_oe_o  (oe),
        .irq_o    (irq)
    );

    gpio_irq #(.GPIO_NUM(40), .SYNC_STAGES(c_SYNC), .DEBOUNCE_W(c_DW)) u_wide (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .we_i     (we),
        .addr_i   (addr),
        .data_i   (wdata),
        .data_o   (rdata2),
        .io_pin_i (pin2),
        .io_pin_o (pin_o2),
        .io_oe_o  (oe2),
        .irq_o    (irq2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'h00:   return {16'h0, m_dir};
            5'h04:   return {16'h0, m_out};
            5'h08:   return {16'h0, m_filt};
            5'h0C:   return {16'h0, m_rise};
            5'h10:   return {16'h0, m_fall};
            5'h14:   return {16'h0, m_pend};
            5'h18:   return {24'h0, m_t};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: advance the model from pre-edge inputs, then check pad/irq outputs.
    task automatic tick();
        logic [c_N-1:0] s, upd, set, clr;
        if (!rst_n) begin
            m_dir = '0; m_out = '0; m_rise = '0; m_fall = '0;
            m_pend = '0; m_filt = '0; m_last = '0; m_t = '0;
            m_sync_q = {};
            for (int k = 0; k < c_SYNC; k++) m_sync_q.push_back('0);
            for (int i = 0; i < c_N; i++) m_run[i] = 0;
        end else begin
            s   = m_sync_q[0];
            upd = '0;
            for (int i = 0; i < c_N; i++) begin
                // A pin's new level is accepted once it has been seen T+1 cycles in a row.
                if (s[i] == m_last[i]) m_run[i]++;
                else m_run[i] = 1;
                m_last[i] = s[i];
                if (s[i] != m_filt[i] && m_run[i] >= int'(m_t) + 1) upd[i] = 1'b1;
            end
            set    = upd & ((s & m_rise) | (~s & m_fall));
            clr    = (we && addr[4:0] == 5'h14) ? wdata[c_N-1:0] : '0;
            m_pend = (m_pend & ~clr) | set;
            m_filt = m_filt ^ upd;
            if (we) begin
                case (addr[4:0])
                    5'h00: m_dir  = wdata[c_N-1:0];
                    5'h04: m_out  = wdata[c_N-1:0];
                    5'h0C: m_rise = wdata[c_N-1:0];
                    5'h10: m_fall = wdata[c_N-1:0];
                    5'h18: m_t    = wdata[c_DW-1:0];
                    default: ;
                endcase
            end
            void'(m_sync_q.pop_front());
            m_sync_q.push_back(pin);
        end
        @(posedge clk);
        #1;
        chk("irq", {31'h0, irq}, {31'h0, |m_pend});
        chk("io_pin_o", {16'h0, pin_o}, {16'h0, m_out});
        chk("io_oe_o", {16'h0, oe}, {16'h0, m_dir});
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = {27'h0, a}; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a);
        addr = {27'h0, a};
        #1;
        chk(tag, rdata, m_read(a));
    endtask

    task automatic rd_const(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = {27'h0, a};
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        // 1: reset dominates a concurrent write burst
        rst_n = 1'b0; we = 1'b1; addr = 32'h0; wdata = 32'hFFFF_FFFF; pin = '1;
        repeat (3) tick();
        for (int a = 0; a <= 'h18; a += 4) begin
            addr = a; #1;
            chk("reset_read", rdata, 32'h0);
        end
        chk("reset_oe", {16'h0, oe}, 32'h0);
        chk("reset_pin_o", {16'h0, pin_o}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        we = 1'b0; pin = '0;
        rst_n = 1'b1;
        repeat (4) tick();

        // 2: outputs follow DIR/OUT
        wr(5'h00, 32'h0000_00F0);
        wr(5'h04, 32'h0000_00A5);
        chk("oe_dir", {16'h0, oe}, 32'h0000_00F0);
        chk("pin_out", {16'h0, pin_o}, 32'h0000_00A5);
        rd_const("read_out", 5'h04, 32'h0000_00A5);

        // 3: debounce with T=3: 3-cycle glitch rejected, 4-cycle level accepted
        wr(5'h18, 32'd3);
        pin[0] = 1'b1;
        repeat (3) tick();
        pin[0] = 1'b0;
        repeat (8) tick();
        rd_const("glitch_in", 5'h08, 32'h0);
        pin[0] = 1'b1;
        for (int k = 1; k <= c_SYNC + 4; k++) begin
            tick();
            rd_const("debounce_in", 5'h08, (k >= c_SYNC + 4) ? 32'h1 : 32'h0);
        end
        pin[0] = 1'b0;
        repeat (8) tick();
        rd("in_low", 5'h08);

        // 4: edge interrupts with T=0
        wr(5'h18, 32'd0);
        pin[1] = 1'b1;
        repeat (5) tick();
        wr(5'h0C, 32'h1);
        wr(5'h10, 32'h2);
        pin[0] = 1'b1;
        for (int k = 1; k <= c_SYNC + 1; k++) begin
            tick();
            chk("irq_latency", {31'h0, irq}, (k >= c_SYNC + 1) ? 32'h1 : 32'h0);
        end
        rd_const("pend_rise", 5'h14, 32'h1);
        pin[1] = 1'b0;
        repeat (5) tick();
        rd_const("pend_fall", 5'h14, 32'h3);
        pin[0] = 1'b0;
        repeat (5) tick();
        rd_const("pend_nofall0", 5'h14, 32'h3);

        // 5: set wins over a same-cycle W1C; plain W1C clears
        wr(5'h14, 32'h2);
        rd_const("pend_clr1", 5'h14, 32'h1);
        pin[0] = 1'b1;
        repeat (c_SYNC) tick();
        wr(5'h14, 32'h1);
        rd_const("w1c_race", 5'h14, 32'h1);
        wr(5'h14, 32'h1);
        rd_const("w1c_clear", 5'h14, 32'h0);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // 6: clamp to bus width and unmapped offset
        wr(5'h00, 32'hFFFF_FFFF);
        rd_const("dir_mask16", 5'h00, 32'h0000_FFFF);
        chk("wide_dir", rdata2, 32'hFFFF_FFFF);
        chk("wide_oe", oe2, 32'hFFFF_FFFF);
        wr(5'h1C, 32'hFFFF_FFFF);
        rd_const("unmapped", 5'h1C, 32'h0);
        chk("wide_unmapped", rdata2, 32'h0);

        // 7: randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int act;
            logic [4:0] ra;
            if (n == 1500) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            pin = pin ^ c_N'($urandom & $urandom & $urandom & $urandom);
            act = $urandom_range(0, 11);
            case (act)
                0: wr(5'h0C, $urandom);
                1: wr(5'h10, $urandom);
                2: wr(5'h14, $urandom);
                3: wr(5'h18, $urandom_range(0, 4));
                4: wr(5'h04, $urandom);
                5: wr(5'h00, $urandom);
                default: tick();
            endcase
            ra = 5'($urandom_range(0, 7) * 4);
            rd("rand_read", ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
